// File: rtl/vector_mac_serial.sv
// rtl/vector_mac_serial.sv - serial signed dot product, one MAC per clock, valid/ready in and out
module vector_mac_serial #(
  parameter  int WIDTH  = 8,
  parameter  int LENGTH = 4,
  localparam int OUTW   = 2*WIDTH + $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a [LENGTH],
  input  logic [WIDTH-1:0] w [LENGTH],
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUTW-1:0]  sum,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IDXW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic signed [OUTW-1:0] acc_q, acc_d;
  logic signed [OUTW-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]       a_q [LENGTH];
  logic [WIDTH-1:0]       a_d [LENGTH];
  logic [WIDTH-1:0]       w_q [LENGTH];
  logic [WIDTH-1:0]       w_d [LENGTH];

  logic signed [WIDTH-1:0]   a_cur, w_cur;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [OUTW-1:0]    acc_next;

  // Size casts of signed operands sign-extend, giving a full-precision product.
  assign a_cur    = a_q[idx_q];
  assign w_cur    = w_q[idx_q];
  assign prod     = (2*WIDTH)'(a_cur) * (2*WIDTH)'(w_cur);
  assign acc_next = acc_q + OUTW'(prod);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    a_d     = a_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          w_d     = w;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_next;
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_next;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        a_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      w_q     <= w_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_vector_mac_serial.sv
// tb/tb_vector_mac_serial.sv - directed and random checks of vector_mac_serial against a dot-product model
module tb_vector_mac_serial;
  localparam int L     = 4;
  localparam int OUTW  = 18;
  localparam int OUTW1 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]      a [L];
  logic [7:0]      w [L];
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [OUTW-1:0] sum;

  logic [7:0]       a1 [1];
  logic [7:0]       w1 [1];
  logic             iv1, ir1, ov1, or1;
  logic [OUTW1-1:0] s1;

  int total = 0;
  int bad   = 0;

  vector_mac_serial #(.WIDTH(8), .LENGTH(L)) dut (
    .clk(clk), .rst(rst), .a(a), .w(w), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .out_valid(out_valid), .out_ready(out_ready)
  );

  vector_mac_serial #(.WIDTH(8), .LENGTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .w(w1), .in_valid(iv1), .in_ready(ir1),
    .sum(s1), .out_valid(ov1), .out_ready(or1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint dot(input int av[L], input int wv[L]);
    longint s = 0;
    for (int i = 0; i < L; i++) s += longint'(av[i]) * longint'(wv[i]);
    return s;
  endfunction

  // Full transaction with out_ready high: accept, scramble inputs, time the result, return to idle.
  task automatic do_vec(input string tag, input int av[L], input int wv[L]);
    int n;
    longint expv;
    expv = dot(av, wv);
    for (int i = 0; i < L; i++) begin
      a[i] = 8'(av[i]);
      w[i] = 8'(wv[i]);
    end
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk({tag, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      a[i] = 8'h00;
      w[i] = 8'($urandom);
    end
    chk({tag, "_busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk({tag, "_latency"}, n, L);
    chk({tag, "_sum"}, $signed(sum), expv);
    step();
    chk({tag, "_idle_ov"}, out_valid, 0);
    chk({tag, "_idle_ir"}, in_ready, 1);
    chk({tag, "_held"}, $signed(sum), expv);
  endtask

  initial begin
    int n;
    int av[L];
    int wv[L];
    int x, y;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; iv1 = 1'b0; or1 = 1'b1;
    for (int i = 0; i < L; i++) begin a[i] = 8'h00; w[i] = 8'h00; end
    a1[0] = 8'h00; w1[0] = 8'h00;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", $signed(sum), 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    do_vec("basic", '{1, 2, 3, 4}, '{5, 6, 7, 8});
    do_vec("neg_neg", '{-128, -128, -128, -128}, '{-128, -128, -128, -128});
    do_vec("neg_pos", '{-128, -128, -128, -128}, '{127, 127, 127, 127});

    // Backpressure with a second vector waiting on in_valid.
    for (int i = 0; i < L; i++) begin a[i] = 8'(i + 1); w[i] = 8'(i + 5); end
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    for (int i = 0; i < L; i++) begin a[i] = 8'd1; w[i] = 8'd2; end
    chk("bp_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("bp_latency", n, L);
    chk("bp_sum", $signed(sum), 70);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_sum", $signed(sum), 70);
      chk("bp_hold_ir", in_ready, 0);
      chk("bp_hold_ov", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_ir", in_ready, 1);
    chk("bp_idle_ov", out_valid, 0);
    step();
    chk("bp_second_accepted", in_ready, 0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("bp2_latency", n, L);
    chk("bp2_sum", $signed(sum), 8);
    step();

    // Reset two cycles into accumulation.
    for (int i = 0; i < L; i++) begin a[i] = 8'(i + 1); w[i] = 8'(i + 5); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("abort_ov", out_valid, 0);
    chk("abort_sum", $signed(sum), 0);
    chk("abort_ir", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("abort_after_ir", in_ready, 1);
    chk("abort_after_ov", out_valid, 0);
    do_vec("after_abort", '{1, 2, 3, 4}, '{5, 6, 7, 8});

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < L; i++) begin
        av[i] = int'($urandom_range(0, 255)) - 128;
        wv[i] = int'($urandom_range(0, 255)) - 128;
      end
      do_vec("rand", av, wv);
    end

    // Single-element build.
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        x = -3; y = 7;
      end else begin
        x = int'($urandom_range(0, 255)) - 128;
        y = int'($urandom_range(0, 255)) - 128;
      end
      a1[0] = 8'(x); w1[0] = 8'(y); iv1 = 1'b1;
      n = 0;
      while (!ir1 && n < 50) begin step(); n++; end
      step();
      iv1 = 1'b0;
      a1[0] = 8'($urandom);
      chk("len1_busy", ir1, 0);
      n = 0;
      while (!ov1 && n < 50) begin step(); n++; end
      chk("len1_latency", n, 1);
      chk("len1_sum", $signed(s1), longint'(x) * longint'(y));
      step();
      chk("len1_idle", ir1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
